// File: rtl/if_id_stage_if.sv
// Fetch-side bus of the IF stage: hazard/redirect controls, instruction ROM port
// and the IF/ID register contents presented to decode.
interface if_id_stage_if;
  logic        stop;
  logic        jump;
  logic [31:0] jump_pc;
  logic [31:0] irom_inst;
  logic [31:0] irom_addr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_have_inst;
  logic [31:0] fetch_cnt;

  // master: the fetch stage itself; slave: hazard unit, EX, ROM and decode
  modport master (
    input  stop, jump, jump_pc, irom_inst,
    output irom_addr, id_pc, id_pc4, id_inst, id_have_inst, fetch_cnt
  );
  modport slave (
    output stop, jump, jump_pc, irom_inst,
    input  irom_addr, id_pc, id_pc4, id_inst, id_have_inst, fetch_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID pipeline register. Owns the PC, honours jump (flush)
// over stop (hold), otherwise advances by one word per cycle.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  if_id_stage_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_have_q, id_have_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d      = pc_q;
    id_pc_d   = id_pc_q;
    id_pc4_d  = id_pc4_q;
    id_inst_d = id_inst_q;
    id_have_d = id_have_q;
    cnt_d     = cnt_q;
    if (bus.jump) begin
      // Redirect squashes the wrong-path fetch; the bubble is not counted
      pc_d      = {bus.jump_pc[31:2], 2'b00};
      id_pc_d   = '0;
      id_pc4_d  = '0;
      id_inst_d = '0;
      id_have_d = 1'b0;
    end else if (!bus.stop) begin
      pc_d      = pc_plus4;
      id_pc_d   = pc_q;
      id_pc4_d  = pc_plus4;
      id_inst_d = bus.irom_inst;
      id_have_d = 1'b1;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      id_pc_q   <= '0;
      id_pc4_q  <= '0;
      id_inst_q <= '0;
      id_have_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      id_pc_q   <= id_pc_d;
      id_pc4_q  <= id_pc4_d;
      id_inst_q <= id_inst_d;
      id_have_q <= id_have_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.irom_addr    = pc_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_pc4       = id_pc4_q;
  assign bus.id_inst      = id_inst_q;
  assign bus.id_have_inst = id_have_q;
  assign bus.fetch_cnt    = cnt_q;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register of the five-stage RV32 pipelined CPU. It owns the program counter, drives the instruction-ROM address, and latches each fetched instruction with its PC, PC+4 and a valid flag for the decode stage. It obeys the same `stop` (load-use stall) and `jump` (taken branch/jump from EX) controls as the ID/EX register, and keeps a fetch counter for the trace harness.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `stop`  in  1: stall request from the hazard unit.
- `jump`  in  1: redirect request from EX (taken branch or jal/jalr).
- `jump_pc`  in  32: redirect target; bits [1:0] ignored and treated as 0.
- `irom_inst`  in  32: instruction word returned combinationally for `irom_addr`.
- `irom_addr`  out  32: current PC, equal to the internal PC register.
- `id_pc`  out  32: PC of the instruction held in IF/ID.
- `id_pc4`  out  32: `id_pc + 4`, registered, modulo 2^32.
- `id_inst`  out  32: instruction held in IF/ID.
- `id_have_inst`  out  1: IF/ID holds a real instruction (trace valid).
- `fetch_cnt`  out  32: number of instructions delivered into IF/ID since reset.

## Operation
- State: `pc` (32), IF/ID register (`id_pc`, `id_pc4`, `id_inst`, `id_have_inst`), `fetch_cnt` (32).
- Reset values (reset low, asynchronous): `pc` = `RESET_PC`, so `irom_addr` = `RESET_PC`. `id_pc` = 0, `id_pc4` = 0, `id_inst` = 0, `id_have_inst` = 0, `fetch_cnt` = 0.
- Each rising edge with reset high, exactly one mode applies, in priority order:
  - Jump (`jump`=1, regardless of `stop`):
    - `pc` <= {`jump_pc`[31:2], 2'b00}.
    - IF/ID flushed: all fields <= 0, including `id_have_inst`.
    - `fetch_cnt` unchanged.
  - Stall (`stop`=1, `jump`=0):
    - `pc` and the whole IF/ID register hold their values.
    - `fetch_cnt` unchanged.
  - Advance (both 0):
    - `pc` <= `pc` + 4.
    - `id_pc` <= `pc`, `id_pc4` <= `pc` + 4, `id_inst` <= `irom_inst`, `id_have_inst` <= 1.
    - `fetch_cnt` <= `fetch_cnt` + 1.
- Arithmetic: all PC additions are 32-bit unsigned and wrap. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `fetch_cnt` wraps from 32'hFFFF_FFFF to 0.
- No decoding is done here. Illegal or zero instruction words are passed through unchanged.
- `jump` and `stop` are sampled only at the clock edge. They have no combinational path to any output.

## Timing
- `irom_addr` is a registered output. It changes only on the clock edge or on reset assertion.
- Fetch-to-decode latency is 1 cycle: the word at `irom_addr` in cycle N appears on `id_inst` in cycle N+1.
- Stall:
  - Each cycle `stop` is high holds IF/ID for exactly that edge.
  - The held instruction is re-presented to ID and is not re-fetched or re-counted.
- Redirect bubbles:
  - `jump` in cycle N: cycle N+1 shows a bubble (`id_have_inst`=0) and `irom_addr`=target.
  - Cycle N+2 shows the target instruction with `id_have_inst`=1.
  - Two consecutive `jump` cycles: the second target wins and IF/ID stays flushed.
- Reset release: the first edge with reset high performs a normal advance. `id_have_inst` rises after that first edge.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Any pending stall or jump is discarded.

## Test plan
- Reset, then 3 free-running cycles with ROM[0]=0x00500093, ROM[4]=0x00A00113 -> after edge 1: `id_pc`=0, `id_inst`=0x00500093, `id_have_inst`=1, `irom_addr`=4. After edge 3: `fetch_cnt`=3, `irom_addr`=0xC.
- Hold `stop`=1 for 2 edges while `id_pc`=0x8 -> `id_pc`, `id_inst`, `irom_addr`=0xC and `fetch_cnt` all unchanged. The next free edge gives `id_pc`=0xC.
- `jump`=1 with `jump_pc`=0x103 at `irom_addr`=0x10 -> next cycle: `irom_addr`=0x100, `id_have_inst`=0, `id_inst`=0. Following edge: `id_pc`=0x100, `id_pc4`=0x104.
- `jump`=1 and `stop`=1 in the same cycle, `jump_pc`=0x40 -> jump wins: `irom_addr`=0x40, IF/ID flushed, `fetch_cnt` unchanged.
- `jump_pc`=0xFFFF_FFFC, then one advance -> `id_pc`=0xFFFF_FFFC, `id_pc4`=0, `irom_addr`=0.
- Assert reset between clock edges while `irom_addr`=0x20 and `fetch_cnt`=8 -> immediately `irom_addr`=`RESET_PC`, all IF/ID fields 0, `fetch_cnt`=0. Repeat with `RESET_PC`=0x1000 -> `irom_addr`=0x1000.
